cla_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor.
- WIDTH is split into NBLK = WIDTH/BLOCK lookahead groups. Each group is resolved in its own pipeline stage, and group carries are registered between stages.
- Accepts one operation per cycle under a valid/ready handshake. Produces sum, carry-out, signed overflow and zero flags, and returns a passthrough tag.
- Sits between operand-issue logic and the writeback/flag logic of the datapath.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_group.sv | 54 +++++
 rtl/cla_pipe_addsub.sv | 148 ++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared sizing helpers and the result-flag bundle for the pipelined
// carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_BLOCK = 4;
  localparam int CLA_TAG_W = 4;

  // Number of lookahead groups, which is also the number of pipeline stages.
  function automatic int cla_nblk(input int width, input int block);
    return (block < 1) ? 0 : width / block;
  endfunction

  // Cycles from the accept edge to out_valid at the default sizing.
  localparam int CLA_LATENCY = cla_nblk(CLA_WIDTH, CLA_BLOCK);

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } cla_flags_t;

endpackage

// File: rtl/cla_group.sv
// BLOCK-bit carry-lookahead group: sum bits, group propagate/generate,
// group carry-out and the carry into the group's top bit.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             p_o,
  output logic             g_o,
  output logic             cout_o,
  output logic             ctop_o
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] c;

  // Carry into bit n as a single sum of products, so no carry waits on another.
  function automatic logic la_carry(input logic [BLOCK-1:0] pv,
                                    input logic [BLOCK-1:0] gv,
                                    input logic             ci,
                                    input int               n);
    logic acc;
    logic term;
    acc = ci;
    for (int m = 0; m < n; m++) acc = acc & pv[m];
    for (int j = 0; j < n; j++) begin
      term = gv[j];
      for (int m = j + 1; m < n; m++) term = term & pv[m];
      acc = acc | term;
    end
    return acc;
  endfunction

  assign p    = a_i ^ b_i;
  assign g    = a_i & b_i;
  assign c[0] = cin_i;

  genvar gi;
  for (gi = 1; gi < BLOCK; gi++) begin : g_carry
    assign c[gi] = la_carry(p, g, cin_i, gi);
  end

  assign sum_o  = p ^ c;
  assign p_o    = &p;
  assign g_o    = la_carry(p, g, 1'b0, BLOCK);
  assign cout_o = g_o | (p_o & cin_i);
  assign ctop_o = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead group resolved per
// stage, group carries registered between stages, one global stall enable.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLOCK = CLA_BLOCK,
  parameter int TAG_W = CLA_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NBLK = cla_nblk(WIDTH, BLOCK);

  if (BLOCK < 1) begin : g_bad_block
    $error("cla_pipe_addsub: BLOCK must be at least 1");
  end else if ((WIDTH < BLOCK) || (WIDTH % BLOCK != 0)) begin : g_bad_width
    $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Operation in flight: operands travel whole; sum bits below the groups
  // already resolved are final, carry is the carry into the next group.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } stage_t;

  // pipe_q[k] holds the operation after group k; the last entry is the output.
  stage_t           pipe_q [NBLK];
  stage_t           issue_d;
  logic [WIDTH-1:0] last_sum;
  logic [NBLK-1:0]  grp_p;
  logic [NBLK-1:0]  grp_g;
  logic [NBLK-1:0]  grp_cout;
  logic [NBLK-1:0]  grp_ctop;
  logic [NBLK-1:0]  unused_grp;
  logic             unused_out;
  cla_flags_t       flags_q;
  cla_flags_t       flags_d;
  logic             adv;

  assign adv      = !pipe_q[NBLK-1].valid || out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1; a borrow-in removes that extra one.
  always_comb begin
    issue_d       = '0;
    issue_d.valid = in_valid;
    issue_d.sub   = in_sub;
    issue_d.tag   = in_tag;
    issue_d.a     = in_a;
    issue_d.b     = in_b ^ {WIDTH{in_sub}};
    issue_d.carry = in_cin ^ in_sub;
  end

  genvar gi;
  for (gi = 0; gi < NBLK; gi++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [BLOCK-1:0] grp_sum;

    if (gi == 0) begin : g_first
      assign src = issue_d;
    end else begin : g_next
      assign src = pipe_q[gi-1];
    end

    cla_group #(
      .BLOCK (BLOCK)
    ) u_group (
      .a_i    (src.a[gi*BLOCK +: BLOCK]),
      .b_i    (src.b[gi*BLOCK +: BLOCK]),
      .cin_i  (src.carry),
      .sum_o  (grp_sum),
      .p_o    (grp_p[gi]),
      .g_o    (grp_g[gi]),
      .cout_o (grp_cout[gi]),
      .ctop_o (grp_ctop[gi])
    );

    always_comb begin
      nxt                        = src;
      nxt.sum[gi*BLOCK +: BLOCK] = grp_sum;
      nxt.carry                  = grp_cout[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_q[gi] <= '0;
      end else if (adv) begin
        pipe_q[gi] <= nxt;
      end
    end

    if (gi == NBLK - 1) begin : g_last
      assign last_sum = nxt.sum;
    end

    assign unused_grp[gi] = grp_p[gi] ^ grp_g[gi] ^ grp_ctop[gi];
  end

  // Overflow is the carry into the MSB disagreeing with the carry out of it.
  always_comb begin
    flags_d      = '0;
    flags_d.cout = grp_cout[NBLK-1];
    flags_d.ovf  = grp_ctop[NBLK-1] ^ grp_cout[NBLK-1];
    flags_d.zero = ~|last_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (adv) begin
      flags_q <= flags_d;
    end
  end

  assign unused_out = ^{pipe_q[NBLK-1].a, pipe_q[NBLK-1].b,
                        pipe_q[NBLK-1].carry, pipe_q[NBLK-1].sub, unused_grp};

  assign out_valid = pipe_q[NBLK-1].valid;
  assign out_sum   = pipe_q[NBLK-1].sum;
  assign out_tag   = pipe_q[NBLK-1].tag;
  assign out_cout  = flags_q.cout;
  assign out_ovf   = flags_q.ovf;
  assign out_zero  = flags_q.zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed corner cases, random traffic with random
// backpressure against an arithmetic reference, a long stall and a mid-flight reset.
module tb_cla_pipe_addsub;

  localparam int W   = 16;
  localparam int TW  = 4;
  localparam int LAT = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct {
    logic          valid;
    logic          ready_in;
    logic          dlv;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
  } obs_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
  } vec_t;

  res_t exp_q[$];

  cla_pipe_addsub #(
    .WIDTH (W),
    .BLOCK (4),
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 input logic [TW-1:0] tag);
    res_t r;
    int ua, ub, sa, sb, ci, full, sres;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = cin ? 1 : 0;
    if (sub) begin
      full   = ua - ub - ci;
      sres   = sa - sb - ci;
      r.cout = (full >= 0);
    end else begin
      full   = ua + ub + ci;
      sres   = sa + sb + ci;
      r.cout = (full >= (1 << W));
    end
    r.sum  = full[W-1:0];
    r.ovf  = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    r.zero = (r.sum == '0);
    r.tag  = tag;
    return r;
  endfunction

  // One clock: sample at the falling edge, record accepts, return after the rising edge.
  task automatic tick(output obs_t o, output bit acc);
    @(negedge clk);
    o.valid    = out_valid;
    o.ready_in = in_ready;
    o.dlv      = out_valid && out_ready;
    o.sum      = out_sum;
    o.cout     = out_cout;
    o.ovf      = out_ovf;
    o.zero     = out_zero;
    o.tag      = out_tag;
    acc        = in_valid && in_ready;
    if (acc) exp_q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_sum !== '0) begin n_err++; $display("FAIL reset_out_sum: got %h want 0000", out_sum); end
    n_vec++; if (out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
    n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    n_vec++; if (out_zero !== 1'b0) begin n_err++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
    n_vec++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    vec_t tab[4];
    obs_t o;
    bit   acc;
    int   lat;
    tab[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 4'h3, 16'h0100, 1'b0, 1'b0, 1'b0};
    tab[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h5, 16'h8000, 1'b0, 1'b1, 1'b0};
    tab[2] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 4'h9, 16'h0000, 1'b1, 1'b0, 1'b1};
    tab[3] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 4'hC, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = tab[i].a; in_b = tab[i].b; in_cin = tab[i].cin; in_sub = tab[i].sub;
      in_tag = tab[i].tag; in_valid = 1'b1;
      tick(o, acc);
      in_valid = 1'b0;
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL dir%0d_accept: got %b want 1", i, acc); end
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        tick(o, acc);
        if (o.valid) lat = c;
      end
      n_vec++; if (lat != LAT) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
      n_vec++; if (o.sum !== tab[i].sum) begin n_err++; $display("FAIL dir%0d_sum: got %h want %h", i, o.sum, tab[i].sum); end
      n_vec++; if (o.cout !== tab[i].cout) begin n_err++; $display("FAIL dir%0d_cout: got %b want %b", i, o.cout, tab[i].cout); end
      n_vec++; if (o.ovf !== tab[i].ovf) begin n_err++; $display("FAIL dir%0d_ovf: got %b want %b", i, o.ovf, tab[i].ovf); end
      n_vec++; if (o.zero !== tab[i].zero) begin n_err++; $display("FAIL dir%0d_zero: got %b want %b", i, o.zero, tab[i].zero); end
      n_vec++; if (o.tag !== tab[i].tag) begin n_err++; $display("FAIL dir%0d_tag: got %h want %h", i, o.tag, tab[i].tag); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random();
    obs_t o;
    obs_t prev;
    bit   acc;
    bit   hold;
    res_t e;
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick(o, acc);
      n_vec++;
      if (o.ready_in !== (!o.valid || out_ready)) begin
        n_err++; $display("FAIL rnd_in_ready: got %b want %b", o.ready_in, (!o.valid || out_ready));
      end
      if (hold) begin
        n_vec++;
        if (!o.valid || o.sum !== prev.sum || o.tag !== prev.tag || o.cout !== prev.cout ||
            o.ovf !== prev.ovf || o.zero !== prev.zero) begin
          n_err++; $display("FAIL rnd_stable: got v=%b sum=%h tag=%h want v=1 sum=%h tag=%h",
                            o.valid, o.sum, o.tag, prev.sum, prev.tag);
        end
      end
      if (o.dlv) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra: got result sum=%h tag=%h want none", o.sum, o.tag);
        end else begin
          e = exp_q.pop_front();
          if ({o.sum, o.cout, o.ovf, o.zero, o.tag} !== {e.sum, e.cout, e.ovf, e.zero, e.tag}) begin
            n_err++; $display("FAIL rnd_result: got sum=%h c=%b v=%b z=%b tag=%h want sum=%h c=%b v=%b z=%b tag=%h",
                              o.sum, o.cout, o.ovf, o.zero, o.tag, e.sum, e.cout, e.ovf, e.zero, e.tag);
          end
        end
      end
      prev = o;
      hold = o.valid && !out_ready;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      tick(o, acc);
      if (o.dlv) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({o.sum, o.cout, o.ovf, o.zero, o.tag} !== {e.sum, e.cout, e.ovf, e.zero, e.tag}) begin
          n_err++; $display("FAIL drain_result: got sum=%h tag=%h want sum=%h tag=%h", o.sum, o.tag, e.sum, e.tag);
        end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_empty: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    obs_t snap;
    bit   acc;
    bit   new_op;
    bit   seen;
    int   issued;
    int   got;
    int   stall;
    int   stall_ticks;
    res_t e;
    issued = 0; got = 0; stall = 0; stall_ticks = 0; seen = 1'b0; new_op = 1'b1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (!seen && out_valid) begin seen = 1'b1; stall = 5; end
      out_ready = (stall == 0);
      if (new_op && issued < 6) begin
        in_a = W'($urandom); in_b = W'($urandom);
        in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
        in_tag = TW'(issued);
      end
      in_valid = (issued < 6);
      tick(o, acc);
      new_op = acc;
      if (acc) issued++;
      if (stall > 0) begin
        n_vec++; if (o.ready_in !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", o.ready_in); end
        if (stall_ticks == 0) snap = o;
        else begin
          n_vec++;
          if (!o.valid || o.sum !== snap.sum || o.tag !== snap.tag || o.cout !== snap.cout ||
              o.ovf !== snap.ovf || o.zero !== snap.zero) begin
            n_err++; $display("FAIL bp_stable: got v=%b sum=%h tag=%h want v=1 sum=%h tag=%h",
                              o.valid, o.sum, o.tag, snap.sum, snap.tag);
          end
        end
        stall_ticks++;
        stall--;
      end
      if (o.dlv) begin
        n_vec++;
        if (o.tag !== TW'(got)) begin n_err++; $display("FAIL bp_order: got tag %h want %h", o.tag, TW'(got)); end
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_extra: got result tag=%h want none", o.tag);
        end else begin
          e = exp_q.pop_front();
          if ({o.sum, o.cout, o.ovf, o.zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
            n_err++; $display("FAIL bp_result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                              o.sum, o.cout, o.ovf, o.zero, e.sum, e.cout, e.ovf, e.zero);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_vec++; if (stall_ticks != 5) begin n_err++; $display("FAIL bp_stall_seen: got %0d stall cycles want 5", stall_ticks); end
    n_vec++; if (got != 6) begin n_err++; $display("FAIL bp_count: got %0d results want 6", got); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_midflight_reset();
    obs_t o;
    bit   acc;
    int   stale;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'b0; in_sub = 1'b0;
      in_tag = TW'(c + 8); in_valid = 1'b1;
      tick(o, acc);
    end
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mrst_pre_valid: got %b want 1", out_valid); end
    #3 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_async_valid: got %b want 0", out_valid); end
    n_vec++; if (out_sum !== '0) begin n_err++; $display("FAIL mrst_async_sum: got %h want 0000", out_sum); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #3 rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_first_ready: got %b want 1", in_ready); end
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick(o, acc);
      if (o.valid) stale++;
    end
    n_vec++; if (stale != 0) begin n_err++; $display("FAIL mrst_stale: got %0d results want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_midflight_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
